// File: rtl/fn_sw_pipe_if.sv
// Operand/result handshake bundle for fn_sw_pipe.
// The master side is the operand source plus result consumer; the slave side is the pipe itself.
interface fn_sw_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             carry;
  logic             zero;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, a, b, sel, out_ready,
    input  in_ready, out_valid, y, carry, zero, op_count
  );

  modport slave (
    input  in_valid, a, b, sel, out_ready,
    output in_ready, out_valid, y, carry, zero, op_count
  );
endinterface

// File: rtl/fn_sw_pipe.sv
// Eight-operation function unit with valid/ready handshakes and a DEPTH-entry result FIFO.
// The FIFO head is kept in its own register so y/carry/zero come straight from flops.
module fn_sw_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input logic          clk,
  input logic          rst,
  fn_sw_pipe_if.slave  bus
);
  localparam int unsigned SH_W  = $clog2(WIDTH);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned EW    = WIDTH + 2;

  logic [WIDTH:0]   w_sum, w_diff, w_shl;
  logic [SH_W-1:0]  w_shamt;
  logic [WIDTH-1:0] w_res;
  logic             w_carry, w_zero;
  logic [EW-1:0]    w_entry;

  logic [EW-1:0]    r_mem [DEPTH];
  logic [EW-1:0]    r_head, w_head_d;
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr, w_wr_ptr_d, w_rd_ptr_d;
  logic [CW-1:0]    r_count, w_count_d;
  logic [CNT_W-1:0] r_op_cnt;
  logic             w_push, w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_shamt = bus.b[SH_W-1:0];
  assign w_sum   = {1'b0, bus.a} + {1'b0, bus.b};
  assign w_diff  = {1'b0, bus.a} - {1'b0, bus.b};
  // Bit WIDTH of the widened shift is the last bit pushed out; zero for a shift of 0.
  assign w_shl   = {1'b0, bus.a} << w_shamt;

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    unique case (bus.sel)
      3'd0: w_res = bus.a & bus.b;
      3'd1: w_res = bus.a | bus.b;
      3'd2: w_res = bus.a ^ bus.b;
      3'd3: w_res = ~bus.a;
      3'd4: begin w_res = w_sum[WIDTH-1:0];  w_carry = w_sum[WIDTH];  end
      3'd5: begin w_res = w_diff[WIDTH-1:0]; w_carry = w_diff[WIDTH]; end
      3'd6: begin w_res = w_shl[WIDTH-1:0];  w_carry = w_shl[WIDTH];  end
      3'd7: w_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
    endcase
  end

  assign w_zero  = (w_res == '0);
  assign w_entry = {w_carry, w_zero, w_res};

  assign bus.in_ready  = (r_count < CW'(DEPTH));
  assign bus.out_valid = (r_count != '0);
  assign w_push        = bus.in_valid && bus.in_ready;
  assign w_pop         = bus.out_valid && bus.out_ready;

  always_comb begin
    w_wr_ptr_d = w_push ? ptr_inc(r_wr_ptr) : r_wr_ptr;
    w_rd_ptr_d = w_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr;
    w_count_d  = r_count;
    if (w_push && !w_pop) begin
      w_count_d = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_d = r_count - CW'(1);
    end
    // Empty afterwards: keep the last popped value. A push landing on the new head bypasses memory.
    if (w_count_d == '0) begin
      w_head_d = r_head;
    end else if (w_push && (r_wr_ptr == w_rd_ptr_d)) begin
      w_head_d = w_entry;
    end else begin
      w_head_d = r_mem[w_rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
      r_op_cnt <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_d;
      r_rd_ptr <= w_rd_ptr_d;
      r_count  <= w_count_d;
      r_head   <= w_head_d;
      if (w_pop) begin
        r_op_cnt <= r_op_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.y        = r_head[WIDTH-1:0];
  assign bus.zero     = r_head[WIDTH];
  assign bus.carry    = r_head[WIDTH+1];
  assign bus.op_count = r_op_cnt;
endmodule

// File: tb/tb_fn_sw_pipe.sv
// Self-checking bench for fn_sw_pipe: directed vector table, corner sequences, random traffic
// against a queue-based reference model.
module tb_fn_sw_pipe;
  localparam int unsigned W  = 8;
  localparam int unsigned D  = 2;
  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fn_sw_pipe_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  fn_sw_pipe #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0] y;
    logic       c;
    logic       z;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] sel;
    logic [7:0] y;
    logic       c;
  } vec_t;

  res_t        q[$];
  res_t        last;
  int unsigned mcnt;
  int          errors = 0;
  int          checks = 0;
  vec_t        tv[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on 8-bit unsigned values.
  function automatic res_t ref_op(input int unsigned a, input int unsigned b,
                                  input int unsigned sel);
    int unsigned y = 0;
    int unsigned c = 0;
    int unsigned s;
    res_t r;
    case (sel)
      0: y = a & b;
      1: y = a | b;
      2: y = a ^ b;
      3: y = 255 - a;
      4: begin y = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
      5: begin y = (a + 256 - b) % 256; c = (a < b) ? 1 : 0; end
      6: begin s = b % 8; y = (a << s) % 256; c = (s == 0) ? 0 : ((a >> (8 - s)) & 1); end
      default: y = (a < b) ? 1 : 0;
    endcase
    r.y = 8'(y);
    r.c = c[0];
    r.z = (y == 0);
    return r;
  endfunction

  // One clock: check outputs at the negedge, update the model, step past the posedge.
  task automatic cycle();
    bit   push, pop;
    res_t h;
    @(negedge clk);
    chk("in_ready", bus.in_ready, (q.size() < D));
    chk("out_valid", bus.out_valid, (q.size() != 0));
    h = (q.size() != 0) ? q[0] : last;
    chk("y", bus.y, h.y);
    chk("carry", bus.carry, h.c);
    chk("zero", bus.zero, h.z);
    chk("op_count", bus.op_count, mcnt);
    push = bus.in_valid && (q.size() < D);
    pop  = bus.out_ready && (q.size() != 0);
    if (rst) begin
      q.delete();
      last = '0;
      mcnt = 0;
    end else begin
      if (pop) begin
        last = q.pop_front();
        mcnt = (mcnt + 1) % (1 << CW);
      end
      if (push) q.push_back(ref_op(bus.a, bus.b, bus.sel));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8 && q.size() != 0; k++) cycle();
    chk("drain_empty", bus.out_valid, 1'b0);
  endtask

  task automatic put(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel);
    bus.a   = a;
    bus.b   = b;
    bus.sel = sel;
  endtask

  initial begin
    tv[0]  = '{8'hF0, 8'h3C, 3'd0, 8'h30, 1'b0};
    tv[1]  = '{8'hF0, 8'h3C, 3'd1, 8'hFC, 1'b0};
    tv[2]  = '{8'hF0, 8'h3C, 3'd2, 8'hCC, 1'b0};
    tv[3]  = '{8'hF0, 8'h3C, 3'd3, 8'h0F, 1'b0};
    tv[4]  = '{8'hFF, 8'h01, 3'd4, 8'h00, 1'b1};
    tv[5]  = '{8'h05, 8'h07, 3'd5, 8'hFE, 1'b1};
    tv[6]  = '{8'h81, 8'h01, 3'd6, 8'h02, 1'b1};
    tv[7]  = '{8'h03, 8'h09, 3'd7, 8'h01, 1'b0};
    tv[8]  = '{8'h81, 8'h00, 3'd6, 8'h81, 1'b0};
    tv[9]  = '{8'h01, 8'h07, 3'd6, 8'h80, 1'b0};
    tv[10] = '{8'h80, 8'h09, 3'd6, 8'h00, 1'b1};
    tv[11] = '{8'h7F, 8'h01, 3'd4, 8'h80, 1'b0};
    tv[12] = '{8'h09, 8'h03, 3'd7, 8'h00, 1'b0};
    tv[13] = '{8'h07, 8'h05, 3'd5, 8'h02, 1'b0};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    put(8'h00, 8'h00, 3'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    last = '0;
    mcnt = 0;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_y", bus.y, 8'h00);
    chk("rst_carry", bus.carry, 1'b0);
    chk("rst_zero", bus.zero, 1'b0);
    chk("rst_op_count", bus.op_count, 0);

    // Directed table: each result must be at the head one cycle after accept.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      bus.in_valid = 1'b1;
      put(tv[i].a, tv[i].b, tv[i].sel);
      cycle();
      bus.in_valid = 1'b0;
      chk("tbl_valid", bus.out_valid, 1'b1);
      chk("tbl_y", bus.y, tv[i].y);
      chk("tbl_carry", bus.carry, tv[i].c);
      chk("tbl_zero", bus.zero, (tv[i].y == 8'h00));
      cycle();
      if (i == 3) chk("tbl_op_count4", bus.op_count, 4);
    end

    // Backpressure: two accepts fill the FIFO, the third waits for the first pop.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    put(8'h10, 8'h20, 3'd4);
    cycle();
    put(8'h02, 8'h03, 3'd5);
    cycle();
    chk("bp_full_ready", bus.in_ready, 1'b0);
    put(8'hAA, 8'h55, 3'd2);
    cycle();
    cycle();
    chk("bp_hold_y", bus.y, 8'h30);
    bus.out_ready = 1'b1;
    cycle();
    chk("bp_after_pop_y", bus.y, 8'hFF);
    chk("bp_after_pop_ready", bus.in_ready, 1'b1);
    cycle();
    bus.in_valid = 1'b0;
    chk("bp_third_y", bus.y, 8'hFF);
    cycle();
    chk("bp_third_head", bus.y, 8'hFF);
    drain();

    // Reset with two results buffered: they must never appear.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    put(8'h11, 8'h22, 3'd1);
    cycle();
    put(8'h44, 8'h22, 3'd4);
    cycle();
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    cycle();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    chk("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk("mid_rst_y", bus.y, 8'h00);
    chk("mid_rst_op_count", bus.op_count, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1'b1);
    repeat (3) cycle();

    // Counter wrap: 17 pops on a 4-bit counter.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 17; i++) begin
      put(8'($urandom), 8'($urandom), 3'($urandom));
      cycle();
    end
    drain();
    chk("wrap_op_count", bus.op_count, 1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 1) != 0);
      put(8'($urandom), 8'($urandom), 3'($urandom));
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fn_sw_pipe.md
Name: fn_sw_pipe

Overview:
Parametrised, registered successor of the 2-bit function selector. Applies one of eight operations, chosen by sel, to two WIDTH-bit operands and returns the result with carry and zero flags. Transactions enter and leave through valid/ready handshakes and are held in a DEPTH-entry result FIFO. Sits between an operand source and a result consumer in the demo datapath.

Parameters:
WIDTH, 8, operand/result width (>=2, power of two)
DEPTH, 2, result FIFO entries (>=1)
CNT_W, 16, width of completed-transaction counter

Ports:
clk  input  1  rising-edge clock, sole clock domain
rst  input  1  synchronous active-high reset
in_valid  input  1  operand transaction valid
in_ready  output  1  block can accept operands this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sel  input  3  operation select
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer accepts head this cycle
y  output  WIDTH  result at FIFO head
carry  output  1  carry/borrow flag at FIFO head
zero  output  1  y==0 flag at FIFO head
op_count  output  CNT_W  number of results consumed (out_valid && out_ready)

Behaviour:
- Interface: one clock, clk; reset rst is synchronous, active-high; sampled only on rising clk edge.
- Reset: FIFO emptied (count=0, read/write pointers 0), out_valid=0, y=0, carry=0, zero=0, op_count=0, in_ready=1 from the first cycle after reset. Reset mid-operation discards all buffered results; no output handshake completes in the reset cycle.
- Operations (result computed combinationally from a, b, sel at the accept cycle):
  - 0 AND: a&b, carry=0
  - 1 OR: a|b, carry=0
  - 2 XOR: a^b, carry=0
  - 3 NOT: ~a, carry=0 (b ignored)
  - 4 ADD: (a+b) mod 2^WIDTH, carry = bit WIDTH of the WIDTH+1-bit sum
  - 5 SUB: (a-b) mod 2^WIDTH, carry = borrow (1 iff a<b unsigned)
  - 6 SHL: a << b[log2(WIDTH)-1:0], zeros shifted in; carry = last bit shifted out (0 when shift amount is 0)
  - 7 LTU: y = {WIDTH-1 zeros, (a<b unsigned)}, carry=0
  - zero = (y==0) for every op.
- Input handshake: accept iff in_valid && in_ready. in_ready = (count<DEPTH), combinational from registered count only (no dependence on out_ready). a/b/sel are don't-care when not accepted.
- Output handshake: out_valid = (count!=0). y/carry/zero are the FIFO head, registered; they hold stable while out_valid && !out_ready. Pop iff out_valid && out_ready.
- Latency: result of an operand accepted at edge N is visible with out_valid=1 after edge N when the FIFO was empty (1 cycle); otherwise it queues behind earlier results in strict order.
- Simultaneous push and pop: count unchanged, both pointers advance. At full, in_ready=0 even if out_ready=1 (no pass-through). At empty, a pop cannot occur.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- op_count increments by 1 on each pop, wraps from 2^CNT_W-1 to 0.
- When empty, y/carry/zero hold the last popped values (0 after reset).

Test Plan:
- Reset then ops with out_ready=1, WIDTH=8: (a=0xF0,b=0x3C) sel 0..3 -> y=0x30,0xFC,0xCC,0x0F, carry=0, each 1 cycle after accept; op_count=4.
- Arithmetic: ADD 0xFF+0x01 -> y=0x00, carry=1, zero=1; SUB 0x05-0x07 -> y=0xFE, carry=1; SHL 0x81 by 1 -> y=0x02, carry=1; LTU 3<9 -> y=0x01.
- Backpressure: out_ready=0, push 3 ops with DEPTH=2 -> in_ready drops to 0 after 2 accepts, third held; y stable at first result; release out_ready -> results delivered in order, third accepted after first pop.
- Full with simultaneous pop: FIFO full, out_ready=1, in_valid=1 -> pop occurs, in_ready=0 that cycle, push accepted next cycle; count never exceeds 2.
- Reset mid-stream: 2 results buffered, assert rst one cycle -> out_valid=0, y=0, op_count=0, in_ready=1 next cycle; buffered results never appear.
- Counter wrap with CNT_W=4: 17 consumed results -> op_count=1.
